// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out link bundle: serial bit strobe on one side, valid/ready word port on
// the other. The deserializer uses the slave modport; the serial source and word consumer use master.
interface sipo_deserializer_if #(
    parameter int unsigned N = 8
);
    logic         serial_in;
    logic         shift_en;
    logic         sync;
    logic [N-1:0] parallel_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun;
    logic         clr_ovr;

    modport master (
        output serial_in, shift_en, sync, out_ready, clr_ovr,
        input  parallel_out, out_valid, busy, overrun
    );

    modport slave (
        input  serial_in, shift_en, sync, out_ready, clr_ovr,
        output parallel_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Collects N LSB-first serial bits into a word and presents it on a valid/ready port.
// sync re-aligns framing; overrun is a sticky flag for words dropped under backpressure.
module sipo_deserializer #(
    parameter int unsigned N = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sipo_deserializer_if.slave     bus
);
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic {StIdle, StRecv} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [N-1:0]    pout_q, pout_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;

    logic [N-1:0]    word;
    logic            complete;
    logic            fire;
    logic            drop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        pout_d   = pout_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        complete = 1'b0;
        drop     = 1'b0;
        word     = {bus.serial_in, shreg_q[N-1:1]};
        fire     = valid_q & bus.out_ready;

        if (bus.shift_en) begin
            shreg_d = word;
        end

        // sync overrides framing; a coincident bit starts a fresh word.
        if (bus.sync) begin
            cnt_d   = '0;
            state_d = StIdle;
            if (bus.shift_en) begin
                cnt_d   = CntW'(1);
                state_d = StRecv;
            end
        end else if (bus.shift_en) begin
            if (cnt_q == CntW'(N - 1)) begin
                cnt_d    = '0;
                state_d  = StIdle;
                complete = 1'b1;
            end else begin
                cnt_d   = cnt_q + CntW'(1);
                state_d = StRecv;
            end
        end

        if (complete) begin
            if (!valid_q || fire) begin
                pout_d  = word;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (fire) begin
            valid_d = 1'b0;
        end

        if (drop) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.parallel_out = pout_q;
    assign bus.out_valid    = valid_q;
    assign bus.busy         = (state_q == StRecv);
    assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: a bit-indexed word model checked every cycle,
// plus literal expectations for each scenario.
module tb_sipo_deserializer;
    localparam int unsigned N = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sipo_deserializer_if #(.N(N)) bif ();

    sipo_deserializer #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: bits placed by arrival index, word register with valid/ready and sticky drop flag.
    int           m_cnt;
    logic [N-1:0] m_part;
    logic [N-1:0] m_pout;
    logic         m_valid;
    logic         m_ovr;

    always @(posedge clk or negedge rst_n) begin
        logic fire;
        logic done;
        logic drop;
        if (!rst_n) begin
            m_cnt   = 0;
            m_part  = '0;
            m_pout  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            fire = m_valid && bif.out_ready;
            done = 1'b0;
            drop = 1'b0;
            if (bif.sync) begin
                m_cnt = 0;
                if (bif.shift_en) begin
                    m_part[0] = bif.serial_in;
                    m_cnt     = 1;
                end
            end else if (bif.shift_en) begin
                m_part[m_cnt] = bif.serial_in;
                m_cnt++;
                if (m_cnt == N) begin
                    done  = 1'b1;
                    m_cnt = 0;
                end
            end
            if (done) begin
                if (!m_valid || fire) begin
                    m_pout  = m_part;
                    m_valid = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (fire) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovr = 1'b1;
            else if (bif.clr_ovr) m_ovr = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_pout", 32'(bif.parallel_out), 32'(m_pout));
            check("model_valid", 32'(bif.out_valid), 32'(m_valid));
            check("model_busy", 32'(bif.busy), 32'(m_cnt != 0));
            check("model_ovr", 32'(bif.overrun), 32'(m_ovr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            bif.shift_en = 1'b0;
            step();
        end
        bif.serial_in = b;
        bif.shift_en  = 1'b1;
        step();
        bif.shift_en  = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) send_bit(w[i], 0);
    endtask

    initial begin
        logic [N-1:0] w;
        errors        = 0;
        checks        = 0;
        bif.serial_in = 1'b0;
        bif.shift_en  = 1'b0;
        bif.sync      = 1'b0;
        bif.out_ready = 1'b1;
        bif.clr_ovr   = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("reset_valid", 32'(bif.out_valid), 32'd0);
        check("reset_pout", 32'(bif.parallel_out), 32'd0);
        check("reset_busy", 32'(bif.busy), 32'd0);
        check("reset_ovr", 32'(bif.overrun), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Bits 1,0,1,0,0,1,0,1 back to back -> A5.
        send_word(8'hA5);
        check("a5_valid", 32'(bif.out_valid), 32'd1);
        check("a5_pout", 32'(bif.parallel_out), 32'hA5);
        check("a5_busy", 32'(bif.busy), 32'd0);
        step();
        check("a5_consumed", 32'(bif.out_valid), 32'd0);
        check("a5_hold", 32'(bif.parallel_out), 32'hA5);

        // Same word with 0-3 idle cycles between bits.
        w = 8'hA5;
        for (int i = 0; i < N; i++) begin
            send_bit(w[i], i % 4);
            if (i < N - 1) check("gap_busy", 32'(bif.busy), 32'd1);
        end
        check("gap_pout", 32'(bif.parallel_out), 32'hA5);
        check("gap_valid", 32'(bif.out_valid), 32'd1);
        step();

        // Backpressure: 3C is held, C3 is dropped.
        bif.out_ready = 1'b0;
        send_word(8'h3C);
        check("bp_3c", 32'(bif.parallel_out), 32'h3C);
        check("bp_ovr0", 32'(bif.overrun), 32'd0);
        send_word(8'hC3);
        check("bp_hold", 32'(bif.parallel_out), 32'h3C);
        check("bp_ovr1", 32'(bif.overrun), 32'd1);
        bif.clr_ovr = 1'b1;
        step();
        bif.clr_ovr = 1'b0;
        check("bp_clr", 32'(bif.overrun), 32'd0);
        bif.out_ready = 1'b1;
        step();
        check("bp_drain", 32'(bif.out_valid), 32'd0);

        // Partial word discarded by sync.
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        bif.sync = 1'b1;
        step();
        bif.sync = 1'b0;
        check("sync_busy", 32'(bif.busy), 32'd0);
        send_word(8'h5A);
        check("sync_5a", 32'(bif.parallel_out), 32'h5A);
        step();

        // Consume and refill on the same edge.
        bif.out_ready = 1'b0;
        send_word(8'h11);
        check("refill_11", 32'(bif.parallel_out), 32'h11);
        w = 8'h22;
        for (int i = 0; i < N - 1; i++) send_bit(w[i], 0);
        bif.out_ready = 1'b1;
        send_bit(w[N-1], 0);
        check("refill_valid", 32'(bif.out_valid), 32'd1);
        check("refill_22", 32'(bif.parallel_out), 32'h22);
        check("refill_ovr", 32'(bif.overrun), 32'd0);
        step();

        // sync together with the Nth bit: no word, bit starts a new one.
        w = 8'hFF;
        for (int i = 0; i < N - 1; i++) send_bit(w[i], 0);
        bif.sync = 1'b1;
        send_bit(1'b1, 0);
        bif.sync = 1'b0;
        check("syncn_valid", 32'(bif.out_valid), 32'd0);
        check("syncn_busy", 32'(bif.busy), 32'd1);
        w = 8'h81;
        for (int i = 1; i < N; i++) send_bit(w[i], 0);
        check("syncn_81", 32'(bif.parallel_out), 32'h81);
        step();

        // Asynchronous reset mid-word.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pout", 32'(bif.parallel_out), 32'd0);
        check("arst_valid", 32'(bif.out_valid), 32'd0);
        check("arst_busy", 32'(bif.busy), 32'd0);
        check("arst_ovr", 32'(bif.overrun), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        send_word(8'h96);
        check("arst_96", 32'(bif.parallel_out), 32'h96);
        check("arst_96v", 32'(bif.out_valid), 32'd1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule
